// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline stage register.
//   state_t    : occupancy encoding of a stage (EMPTY, ONE, TWO)
//   RV32I_NOP  : canonical RV32I NOP (addi x0, x0, 0), used as the bubble value
//   XLEN       : default datapath width
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
  localparam int          XLEN      = 32;

endpackage

// File: rtl/stage_data_reg.sv
// stage_data_reg -- n-bit load-enabled register with synchronous reset.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, loads RST_VAL
//   load : capture d at the next edge
//   d    : incoming value
//   q    : held value
module stage_data_reg #(
  parameter int           n       = 32,
  parameter logic [n-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  logic [n-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= RST_VAL;
    end else if (load) begin
      data_reg <= d;
    end
  end

  assign q = data_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline stage register, one cycle latency.
// Build option: define PIPE_STAGE_REG_SKID_EN to add a skid entry so that
// in_ready is registered (no combinational out_ready -> in_ready path).
// Without it the stage holds one entry and in_ready = ~out_valid | out_ready.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (overrides everything)
//   flush     : synchronous discard of all held entries
//   in_valid  : producer offers d
//   in_ready  : stage accepts d this cycle
//   d         : incoming payload
//   out_valid : q holds a valid entry
//   out_ready : consumer takes q this cycle
//   q         : outgoing payload, RST_VAL when empty
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int           n       = XLEN,
  parameter logic [n-1:0] RST_VAL = n'(RV32I_NOP)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] q
);

  state_t       state_reg, state_next;
  logic         in_fire, out_fire;
  logic         main_load;
  logic [n-1:0] main_d, main_q;

  assign out_valid = (state_reg != EMPTY);
  assign out_fire  = out_valid & out_ready;
  assign in_fire   = in_valid & in_ready & ~flush;
  // An emptied stage still holds stale data in main; present the bubble.
  assign q         = out_valid ? main_q : RST_VAL;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic         skid_load;
  logic [n-1:0] skid_q;
  logic         in_ready_reg;

  // Registered ready; masked during reset so nothing is offered-and-lost.
  assign in_ready = in_ready_reg & ~rst;

  always_comb begin
    state_next = state_reg;
    main_load  = 1'b0;
    main_d     = d;
    skid_load  = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          main_load  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load  = 1'b1;
          state_next = TWO;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // Skid is always the younger entry, so it promotes into main.
        if (out_fire) begin
          main_load  = 1'b1;
          main_d     = skid_q;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  stage_data_reg #(.n(n), .RST_VAL(RST_VAL)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (d),
    .q    (skid_q)
  );
`else
  assign in_ready = (~out_valid | out_ready) & ~rst;

  always_comb begin
    state_next = state_reg;
    main_load  = 1'b0;
    main_d     = d;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          main_load  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        // in_fire in ONE implies out_fire: the slot is replaced in place.
        if (in_fire) begin
          main_load = 1'b1;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end
`endif

  stage_data_reg #(.n(n), .RST_VAL(RST_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

endmodule
